// File: rtl/compressor5_3_pipe.sv
// compressor5_3_pipe: pipelined 5:3 bit-column compressor with valid/ready
// flow control and a sideband tag. Each column's ones-count is encoded as
// s1 + 2*s2 + 4*s3. STAGE1_REG selects a register after the first FA layer.
// Optional final carry-propagate adder on sum_out: define COMP53_FINAL_CPA_EN.
module compressor5_3_pipe #(
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned STAGE1_REG = 1,
  parameter int unsigned TAG_W      = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a1,
  input  logic [WIDTH-1:0]   in_a2,
  input  logic [WIDTH-1:0]   in_a3,
  input  logic [WIDTH-1:0]   in_a4,
  input  logic [WIDTH-1:0]   in_a5,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   s1,
  output logic [WIDTH-1:0]   s2,
  output logic [WIDTH-1:0]   s3,
  output logic [TAG_W-1:0]   out_tag,
  output logic [WIDTH+2:0]   sum_out
);

  localparam int unsigned SW = WIDTH + 3;

  // Layer 1 full adders straight from the operand inputs
  logic [WIDTH-1:0] l1_w1, l1_w2;

  // Signals presented by stage 1 (registered or bypassed) to stage 2
  logic             st1_v;
  logic [WIDTH-1:0] st1_w1, st1_w2, st1_a4, st1_a5;
  logic [TAG_W-1:0] st1_tag;

  // Stage 2 state
  logic             v2_q, v2_d;
  logic [WIDTH-1:0] s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [TAG_W-1:0] tag2_q, tag2_d;
  logic             rdy2;

  // Layer 2 / layer 3 intermediates
  logic [WIDTH-1:0] l2_s1, l2_w3, l3_s2, l3_s3;

  // First FA layer: sum and majority of a1..a3
  always_comb begin
    l1_w1 = in_a1 ^ in_a2 ^ in_a3;
    l1_w2 = (in_a1 & in_a2) | (in_a1 & in_a3) | (in_a2 & in_a3);
  end

  assign rdy2 = !v2_q || out_ready;

  generate
    if (STAGE1_REG != 0) begin : g_st1
      logic             v1_q, v1_d;
      logic [WIDTH-1:0] w1_q, w1_d, w2_q, w2_d, a4_q, a4_d, a5_q, a5_d;
      logic [TAG_W-1:0] tag1_q, tag1_d;
      logic             rdy1;

      // Stage 1 load: valid follows input whenever ready; data only on a valid set
      always_comb begin
        rdy1   = !v1_q || rdy2;
        v1_d   = v1_q;
        w1_d   = w1_q;
        w2_d   = w2_q;
        a4_d   = a4_q;
        a5_d   = a5_q;
        tag1_d = tag1_q;
        if (rdy1) begin
          v1_d = in_valid;
          if (in_valid) begin
            w1_d   = l1_w1;
            w2_d   = l1_w2;
            a4_d   = in_a4;
            a5_d   = in_a5;
            tag1_d = in_tag;
          end
        end
      end

      // Stage 1 registers with synchronous clear
      always_ff @(posedge clk) begin
        if (rst) begin
          v1_q   <= 1'b0;
          w1_q   <= '0;
          w2_q   <= '0;
          a4_q   <= '0;
          a5_q   <= '0;
          tag1_q <= '0;
        end else begin
          v1_q   <= v1_d;
          w1_q   <= w1_d;
          w2_q   <= w2_d;
          a4_q   <= a4_d;
          a5_q   <= a5_d;
          tag1_q <= tag1_d;
        end
      end

      assign st1_v    = v1_q;
      assign st1_w1   = w1_q;
      assign st1_w2   = w2_q;
      assign st1_a4   = a4_q;
      assign st1_a5   = a5_q;
      assign st1_tag  = tag1_q;
      assign in_ready = rst || rdy1;
    end else begin : g_bypass
      assign st1_v    = in_valid;
      assign st1_w1   = l1_w1;
      assign st1_w2   = l1_w2;
      assign st1_a4   = in_a4;
      assign st1_a5   = in_a5;
      assign st1_tag  = in_tag;
      assign in_ready = rst || rdy2;
    end
  endgenerate

  // Second FA layer and final HA layer, then stage 2 load decision
  always_comb begin
    l2_s1 = st1_w1 ^ st1_a4 ^ st1_a5;
    l2_w3 = (st1_w1 & st1_a4) | (st1_w1 & st1_a5) | (st1_a4 & st1_a5);
    l3_s2 = st1_w2 ^ l2_w3;
    l3_s3 = st1_w2 & l2_w3;
    v2_d   = v2_q;
    s1_d   = s1_q;
    s2_d   = s2_q;
    s3_d   = s3_q;
    tag2_d = tag2_q;
    if (rdy2) begin
      v2_d = st1_v;
      if (st1_v) begin
        s1_d   = l2_s1;
        s2_d   = l3_s2;
        s3_d   = l3_s3;
        tag2_d = st1_tag;
      end
    end
  end

  // Stage 2 registers with synchronous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      v2_q   <= 1'b0;
      s1_q   <= '0;
      s2_q   <= '0;
      s3_q   <= '0;
      tag2_q <= '0;
    end else begin
      v2_q   <= v2_d;
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      s3_q   <= s3_d;
      tag2_q <= tag2_d;
    end
  end

  assign out_valid = v2_q;
  assign s1        = s1_q;
  assign s2        = s2_q;
  assign s3        = s3_q;
  assign out_tag   = tag2_q;

`ifdef COMP53_FINAL_CPA_EN
  assign sum_out = SW'(s1_q) + (SW'(s2_q) << 1) + (SW'(s3_q) << 2);
`else
  assign sum_out = '0;
`endif

endmodule
